// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the CPU fetch path: address type, fetch FSM
// state encoding and the architectural reset/halt addresses.
package codes;

   typedef logic [31:0] size_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_DATA   = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

   localparam size_t RESET_VECTOR = 32'hBFC00000;
   localparam size_t HALT_ADDR    = 32'h0;

   function automatic logic is_misaligned(input size_t addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/cpu_fetch_watchdog.sv
// Counts consecutive stalled REQ cycles and flags when the limit is reached.
// Only instantiated when CPU_FETCH_TIMEOUT_EN is defined.
module cpu_fetch_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic stall,
   output logic expired
);

   localparam logic [7:0] LIMIT_CNT = 8'(LIMIT);

   logic [7:0] count_q;

   // Saturates at the limit so the flag stays up until the FSM leaves REQ.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= 8'd0;
      end else if (stall && (count_q != LIMIT_CNT)) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign expired = (count_q == LIMIT_CNT);

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: one single-word Avalon read per PC, halts on PC 0 or a
// misaligned PC. Optional REQ stall timeout enabled by CPU_FETCH_TIMEOUT_EN.
module cpu_fetch
   import codes::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic        fetch_req,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        pc_wen_o,
   output logic        busy_o,
   output logic        active_o,
   output logic        fault_o,
   output logic [1:0]  state_o
);

   fetch_state_t state_q, state_d;
   logic         set_fault;
   logic         timeout;
   size_t        addr_q;
   logic [31:0]  instr_q;
   logic         valid_q;
   logic         active_q;
   logic         fault_q;

`ifdef CPU_FETCH_TIMEOUT_EN
   cpu_fetch_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != ST_REQ),
      .stall   ((state_q == ST_REQ) && avm_waitrequest),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      set_fault = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fetch_req) begin
               if (pc_i == HALT_ADDR) begin
                  state_d = ST_HALTED;
               end else if (is_misaligned(pc_i)) begin
                  state_d   = ST_HALTED;
                  set_fault = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // A timeout wins even if the slave releases waitrequest on the same edge.
            if (timeout) begin
               state_d   = ST_HALTED;
               set_fault = 1'b1;
            end else if (!avm_waitrequest) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA:   state_d = ST_IDLE;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b1;
         fault_q  <= 1'b0;
      end else begin
         if (state_d == ST_HALTED) begin
            addr_q <= '0;
         end else if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            addr_q <= pc_i;
         end
         if (state_q == ST_DATA) begin
            instr_q <= avm_readdata;
         end
         valid_q  <= (state_q == ST_DATA);
         active_q <= (state_d != ST_HALTED);
         fault_q  <= fault_q | set_fault;
      end
   end

   assign avm_read       = (state_q == ST_REQ);
   assign avm_byteenable = avm_read ? 4'hF : 4'h0;
   assign avm_address    = addr_q;
   assign busy_o         = (state_q == ST_REQ) || (state_q == ST_DATA);
   assign instr_o        = instr_q;
   assign instr_valid_o  = valid_q;
   assign pc_wen_o       = valid_q;
   assign active_o       = active_q;
   assign fault_o        = fault_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed cases plus randomized fetch,
// halt and reset traffic compared against a transaction-level expectation.
module tb_cpu_fetch;

   localparam int TO = 8;

   logic        clk;
   logic        reset;
   logic [31:0] pc_i;
   logic        fetch_req;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        pc_wen_o;
   logic        busy_o;
   logic        active_o;
   logic        fault_o;
   logic [1:0]  state_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] prev_instr = 32'h0;

   cpu_fetch #(.TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_i            (pc_i),
      .fetch_req       (fetch_req),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .instr_o         (instr_o),
      .instr_valid_o   (instr_valid_o),
      .pc_wen_o        (pc_wen_o),
      .busy_o          (busy_o),
      .active_o        (active_o),
      .fault_o         (fault_o),
      .state_o         (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with reset released.
   task automatic do_reset();
      reset     = 1'b1;
      fetch_req = 1'($urandom_range(0, 1));
      pc_i      = 32'h0000_1000;
      @(negedge clk);
      check("rst_read",  avm_read,       0);
      check("rst_addr",  avm_address,    0);
      check("rst_be",    avm_byteenable, 0);
      check("rst_instr", instr_o,        0);
      check("rst_valid", instr_valid_o,  0);
      check("rst_wen",   pc_wen_o,       0);
      check("rst_busy",  busy_o,         0);
      check("rst_active", active_o,      1);
      check("rst_fault", fault_o,        0);
      reset      = 1'b0;
      fetch_req  = 1'b0;
      prev_instr = 32'h0;
   endtask

   // Expected: read held for waits+1 cycles at pc, capture visible at cycle waits+3.
   task automatic do_fetch(input logic [31:0] pc, input int waits, input logic [31:0] data);
      int stalls = 0;
      pc_i            = pc;
      fetch_req       = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata    = $urandom();
      for (int c = 1; c <= waits + 3; c++) begin
         @(negedge clk);
         fetch_req = 1'b0;
         pc_i      = $urandom();
         if (c <= waits + 1) begin
            check("f_read", avm_read, 1);
            check("f_addr", avm_address, pc);
            check("f_be",   avm_byteenable, 32'hF);
         end else begin
            check("f_read_lo", avm_read, 0);
            check("f_be_lo",   avm_byteenable, 0);
         end
         check("f_busy",   busy_o,   32'(c <= waits + 2));
         check("f_active", active_o, 1);
         if (avm_read) begin
            avm_waitrequest = (stalls < waits);
            if (avm_waitrequest) stalls++;
         end
         if (c == waits + 1) avm_readdata = data;
         else if (c != waits + 2) avm_readdata = $urandom();
         if (c == waits + 3) begin
            check("f_valid", instr_valid_o, 1);
            check("f_wen",   pc_wen_o,      1);
            check("f_instr", instr_o,       data);
            prev_instr = data;
         end else begin
            check("f_valid_lo", instr_valid_o, 0);
            check("f_wen_lo",   pc_wen_o,      0);
            check("f_hold",     instr_o,       prev_instr);
         end
      end
   endtask

   // Halting fetch, then further requests must be ignored until reset.
   task automatic do_halt(input logic [31:0] pc);
      pc_i      = pc;
      fetch_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("h_active", active_o, 0);
         check("h_fault",  fault_o,  32'(pc != 32'h0));
         check("h_read",   avm_read, 0);
         check("h_addr",   avm_address, 0);
         check("h_busy",   busy_o,   0);
         check("h_valid",  instr_valid_o, 0);
         pc_i = 32'hBFC0_0000;
      end
      fetch_req = 1'b0;
      do_reset();
   endtask

   task automatic do_reset_mid_req(input logic [31:0] pc);
      pc_i            = pc;
      fetch_req       = 1'b1;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      check("m_read", avm_read, 1);
      @(negedge clk);
      do_reset();
   endtask

   task automatic do_stuck();
      int rd = 0;
      pc_i            = 32'hBFC0_0040;
      fetch_req       = 1'b1;
      avm_waitrequest = 1'b1;
      for (int c = 1; c <= 310; c++) begin
         @(negedge clk);
         fetch_req = 1'b0;
         if (avm_read) rd++;
      end
`ifdef CPU_FETCH_TIMEOUT_EN
      check("to_reads",  32'(rd), 32'(TO + 1));
      check("to_active", active_o, 0);
      check("to_fault",  fault_o,  1);
      check("to_read",   avm_read, 0);
`else
      check("stk_reads", 32'(rd), 310);
      check("stk_read",  avm_read, 1);
      check("stk_busy",  busy_o,   1);
      check("stk_fault", fault_o,  0);
`endif
      avm_waitrequest = 1'b0;
      do_reset();
   endtask

   initial begin
      reset           = 1'b1;
      fetch_req       = 1'b0;
      pc_i            = 32'h0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h0;
      @(negedge clk);
      do_reset();

      do_fetch(32'hBFC0_0000, 0, 32'h2402_000A);
      do_fetch(32'hBFC0_0000, 4, 32'h2402_000A);
      do_fetch(32'hBFC0_0004, 0, 32'h1111_2222);
      do_fetch(32'hBFC0_0008, 0, 32'h3333_4444);
      do_halt(32'h0);
      do_halt(32'hBFC0_0002);
      do_reset_mid_req(32'hBFC0_0010);
      do_fetch(32'hBFC0_0010, 1, 32'hDEAD_BEEF);
      do_stuck();

      for (int i = 0; i < 60; i++) begin
         int          r;
         logic [31:0] tmp;
         logic [31:0] pc;
         r   = $urandom_range(0, 9);
         tmp = $urandom();
         pc  = tmp & ~32'h3;
         if (pc == 32'h0) pc = 32'h4;
         case (r)
            0: do_halt(32'h0);
            1: do_halt(pc | 32'($urandom_range(1, 3)));
            2: do_reset_mid_req(pc);
            default: do_fetch(pc, $urandom_range(0, 5), $urandom());
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
